cpu_clock_ctrl: RTL and testbench
=================================

Name: cpu_clock_ctrl

Overview:
- Generates the CPU clock for the RV32 pipeline core on the DE1 board, replacing free-running divide-by-two and raw-key manual clocking.
- Supports three clock sources:
  - free-run at a switch-selected rate;
  - debounced single-step from a push-button;
  - run-until-breakpoint, comparing the core's PC against a switch-supplied address.
- Sits between the board clock/keys/switches and the pipeline's clockCPU input. The memory clock is not touched.

Parameters:
BASE_HALF, 25000000, CLOCK_50 cycles per clockCPU half-period at divisor=0 (32-bit).
DEB_CYCLES, 1000000, consecutive stable CLOCK_50 cycles needed to accept a new key level (20 ms).

Ports:
CLOCK_50  in  1  board clock; all logic is on its rising edge.
reset  in  1  asynchronous, active-low reset.
run_mode  in  1  1 = free-run, 0 = manual step.
step_key_n  in  1  raw push-button, active-low, asynchronous to CLOCK_50.
divisor  in  4  half-period = (divisor+1)*BASE_HALF cycles.
bp_enable  in  1  1 = breakpoint compare active.
bp_addr  in  32  breakpoint PC.
pc  in  32  current PC from the pipeline.
clockCPU  out  1  generated CPU clock (registered, glitch-free).
cpu_tick  out  1  one-cycle pulse in the cycle clockCPU goes 0->1.
halted  out  1  1 while stopped at a breakpoint.
state  out  2  0 IDLE, 1 RUN, 2 STEP, 3 BREAK.

Behaviour:
- Reset (reset=0, async):
  - clockCPU=0, cpu_tick=0, halted=0, state=IDLE;
  - half-period counter=0, phase=low;
  - debounced key level=1 (released), synchroniser flops=1.
- Key conditioning:
  - step_key_n passes through a 2-flop synchroniser.
  - The debounced level updates only after the synchronised value differs from it for DEB_CYCLES consecutive cycles; any bounce restarts the count.
  - A press event is a debounced 1->0 transition: a single one-cycle event, with no auto-repeat while held.
- Half-period timing:
  - H = (divisor+1)*BASE_HALF, computed in 32 bits; divisor is sampled at the start of each half-period.
  - A phase ends when the counter reaches H-1. At that point clockCPU toggles and the counter resets to 0.
  - clockCPU changes only at phase ends, so no pulse is ever truncated.
- IDLE:
  - clockCPU=0.
  - If run_mode=1, go to RUN next cycle (counter starts at 0, low phase).
  - Otherwise a press event goes to STEP.
- RUN:
  - Continuous toggling; first rise H cycles after entry.
  - When a low->high toggle occurs, cpu_tick=1 for that cycle.
  - At each high->low toggle, the breakpoint check is made: if run_mode=1, bp_enable=1 and pc==bp_addr, go to BREAK with halted=1.
  - Also at each high->low toggle, if run_mode=0, go to IDLE.
  - The breakpoint check has priority over the run_mode=0 check.
  - run_mode is never acted on mid-high-phase.
- STEP:
  - Exactly one period: low H cycles, then high H cycles (tick at rise), then low again.
  - Press events during STEP are ignored.
  - At the end of the high phase, the next state is:
    - RUN if it was entered from BREAK and run_mode=1;
    - otherwise IDLE.
  - The breakpoint compare is suppressed for this step.
- BREAK:
  - clockCPU=0, halted=1.
  - A press event goes to STEP (halted drops to 0 on entry to STEP).
  - bp_enable=0 or run_mode=0 goes to IDLE (halted=0).
- Simultaneous events: a press event in the same cycle as a run_mode change is resolved by the state-priority rules above; a press is never queued.
- Reset asserted mid-pulse: clockCPU drops to 0 immediately (async). On reset release the block restarts from IDLE.

Test Plan:
- BASE_HALF=2, DEB_CYCLES=4, run_mode=1, divisor=0 after reset -> RUN; first clockCPU rise 2 cycles after RUN entry; then a 4-cycle period; cpu_tick pulses once every 4 cycles.
- divisor=3 -> high 8 cycles, low 8 cycles; divisor changed 0->3 mid-phase -> current phase keeps old length, next phase is 8.
- run_mode=0; step_key_n low for 2 cycles (bounce) -> no tick. Low for 10 cycles -> exactly one 2-cycle high pulse. Held low 200 cycles -> still one pulse. A second press after release -> one more pulse.
- run_mode=1, bp_enable=1, bp_addr=0x0000000C, pc incremented by 4 per tick from 0 -> halted=1 and state=3 after the fall with pc=0x0C, clockCPU stays 0. A press -> one tick, then RUN with halted=0, with no re-break at 0x0C.
- run_mode dropped to 0 one cycle into a high phase -> high lasts the full H, then clockCPU=0, state=IDLE, no further ticks.
- reset pulled low while clockCPU=1 in STEP -> clockCPU=0, state=0, halted=0 in the same cycle; after release, no tick until a new press.

Source files
------------

// File: rtl/cpu_clock_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : cpu_clock_ctrl_if
// Purpose  : Groups the CPU clock controller's control/status signals, i.e.
//            everything except the board clock and reset.
// Ports    : run_mode, step_key_n, divisor, bp_enable, bp_addr, pc
//              (board/core -> controller)
//            clockCPU, cpu_tick, halted, state
//              (controller -> core/board)
// Modports : master = board/core side, slave = clock controller side.
// Revision : 1.0  initial release
// ============================================================================
interface cpu_clock_ctrl_if;
  logic        run_mode;
  logic        step_key_n;
  logic [3:0]  divisor;
  logic        bp_enable;
  logic [31:0] bp_addr;
  logic [31:0] pc;
  logic        clockCPU;
  logic        cpu_tick;
  logic        halted;
  logic [1:0]  state;

  modport master (
    output run_mode, step_key_n, divisor, bp_enable, bp_addr, pc,
    input  clockCPU, cpu_tick, halted, state
  );

  modport slave (
    input  run_mode, step_key_n, divisor, bp_enable, bp_addr, pc,
    output clockCPU, cpu_tick, halted, state
  );
endinterface
`default_nettype wire

// File: rtl/cpu_clock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cpu_clock_ctrl
// Purpose  : Generates the RV32 pipeline clock (clockCPU) from CLOCK_50.
//            Supports three modes:
//              - free-run at a divisor-selected rate;
//              - debounced single-step from a push-button;
//              - run-until-breakpoint on a PC match.
// Ports    : CLOCK_50       board clock; all logic runs on its rising edge
//            reset          asynchronous, active-low reset
//            bus (slave)    run_mode, step_key_n, divisor, bp_enable,
//                           bp_addr and pc in;
//                           clockCPU, cpu_tick, halted and state out
// Revision : 1.0  initial release
// ============================================================================
module cpu_clock_ctrl #(
  parameter logic [31:0] BASE_HALF  = 32'd25000000,
  parameter logic [31:0] DEB_CYCLES = 32'd1000000
) (
  input  wire logic        CLOCK_50,
  input  wire logic        reset,
  cpu_clock_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_STEP  = 2'd2,
    S_BREAK = 2'd3
  } state_t;

  // Registered state
  state_t      state_q,      state_d;
  logic        clk_cpu_q,    clk_cpu_d;
  logic        tick_q,       tick_d;
  logic        halted_q,     halted_d;
  logic        from_break_q, from_break_d;
  logic [31:0] cnt_q,        cnt_d;
  logic [31:0] half_q,       half_d;
  logic        sync1_q,      sync1_d;
  logic        sync2_q,      sync2_d;
  logic        deb_q,        deb_d;
  logic [31:0] deb_cnt_q,    deb_cnt_d;

  // Combinational helpers
  logic        key_differs;
  logic        deb_done;
  logic        press;
  logic [31:0] h_now;
  logic [31:0] h_cur;
  logic        phase_end;
  logic        bp_hit;

  always_comb begin
    // Key conditioning: two-flop synchroniser, then a stability counter.
    // Any bounce back to the current debounced level clears the count.
    sync1_d     = bus.step_key_n;
    sync2_d     = sync1_q;
    key_differs = (sync2_q != deb_q);
    deb_done    = key_differs && (deb_cnt_q == DEB_CYCLES - 32'd1);
    deb_d       = deb_q;
    if (!key_differs) begin
      deb_cnt_d = 32'd0;
    end else if (deb_done) begin
      deb_cnt_d = 32'd0;
      deb_d     = sync2_q;
    end else begin
      deb_cnt_d = deb_cnt_q + 32'd1;
    end
    // A press is the single cycle in which the debounced level falls to 0.
    press = deb_done && !sync2_q;

    // Half-period length is captured in the first cycle of each phase
    // (counter == 0), so a divisor change mid-phase only affects later phases.
    h_now     = ({28'd0, bus.divisor} + 32'd1) * BASE_HALF;
    h_cur     = (cnt_q == 32'd0) ? h_now : half_q;
    half_d    = h_cur;
    phase_end = (cnt_q == h_cur - 32'd1);
    bp_hit    = bus.run_mode && bus.bp_enable && (bus.pc == bus.bp_addr);

    state_d      = state_q;
    clk_cpu_d    = clk_cpu_q;
    tick_d       = 1'b0;
    from_break_d = from_break_q;
    cnt_d        = cnt_q;

    case (state_q)
      S_IDLE: begin
        clk_cpu_d = 1'b0;
        cnt_d     = 32'd0;
        if (bus.run_mode) begin
          state_d = S_RUN;
        end else if (press) begin
          state_d      = S_STEP;
          from_break_d = 1'b0;
        end
      end

      S_RUN, S_STEP: begin
        if (phase_end) begin
          cnt_d     = 32'd0;
          clk_cpu_d = !clk_cpu_q;
          if (!clk_cpu_q) begin
            tick_d = 1'b1;
          end else if (state_q == S_RUN) begin
            // Falling edge in RUN: breakpoint outranks a run_mode drop.
            if (bp_hit) begin
              state_d = S_BREAK;
            end else if (!bus.run_mode) begin
              state_d = S_IDLE;
            end
          end else begin
            // Falling edge ends a step. Resume running only when stepping
            // out of a breakpoint; the compare is skipped for this step.
            state_d = (from_break_q && bus.run_mode) ? S_RUN : S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      S_BREAK: begin
        clk_cpu_d = 1'b0;
        cnt_d     = 32'd0;
        if (press) begin
          state_d      = S_STEP;
          from_break_d = 1'b1;
        end else if (!bus.bp_enable || !bus.run_mode) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d   = S_IDLE;
        clk_cpu_d = 1'b0;
        cnt_d     = 32'd0;
      end
    endcase

    halted_d = (state_d == S_BREAK);
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      clk_cpu_q    <= 1'b0;
      tick_q       <= 1'b0;
      halted_q     <= 1'b0;
      from_break_q <= 1'b0;
      cnt_q        <= 32'd0;
      half_q       <= 32'd0;
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      deb_q        <= 1'b1;
      deb_cnt_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      clk_cpu_q    <= clk_cpu_d;
      tick_q       <= tick_d;
      halted_q     <= halted_d;
      from_break_q <= from_break_d;
      cnt_q        <= cnt_d;
      half_q       <= half_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      deb_q        <= deb_d;
      deb_cnt_q    <= deb_cnt_d;
    end
  end

  assign bus.clockCPU = clk_cpu_q;
  assign bus.cpu_tick = tick_q;
  assign bus.halted   = halted_q;
  assign bus.state    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_clock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_clock_ctrl
// Purpose  : Directed self-checking bench for cpu_clock_ctrl with
//            BASE_HALF=2 and DEB_CYCLES=4.
// Revision : 1.0  initial release
// ============================================================================
module tb_cpu_clock_ctrl;

  logic clk;
  logic reset;
  cpu_clock_ctrl_if bus ();

  cpu_clock_ctrl #(
    .BASE_HALF  (32'd2),
    .DEB_CYCLES (32'd4)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   vectors = 0;
  int   misses  = 0;
  int   ticks   = 0;
  int   highs   = 0;
  logic pc_auto = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      misses++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n clock cycles, sampling 1 ns after each rising edge. Counts
  // tick pulses and high cycles, and models the core's PC advancing by 4
  // on every tick.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (bus.cpu_tick === 1'b1) begin
        ticks++;
        if (pc_auto) bus.pc = bus.pc + 32'd4;
      end
      if (bus.clockCPU === 1'b1) highs++;
    end
  endtask

  task automatic do_reset(input logic rm);
    reset = 1'b0;
    step(2);
    bus.run_mode   = rm;
    bus.step_key_n = 1'b1;
    bus.divisor    = 4'd0;
    bus.bp_enable  = 1'b0;
    bus.bp_addr    = 32'd0;
    bus.pc         = 32'd0;
    pc_auto        = 1'b0;
    reset          = 1'b1;
    ticks          = 0;
    highs          = 0;
  endtask

  initial begin
    reset          = 1'b0;
    bus.run_mode   = 1'b0;
    bus.step_key_n = 1'b1;
    bus.divisor    = 4'd0;
    bus.bp_enable  = 1'b0;
    bus.bp_addr    = 32'd0;
    bus.pc         = 32'd0;
    step(3);
    chk("rst_clk",    {31'd0, bus.clockCPU}, 32'd0);
    chk("rst_tick",   {31'd0, bus.cpu_tick}, 32'd0);
    chk("rst_halted", {31'd0, bus.halted},   32'd0);
    chk("rst_state",  {30'd0, bus.state},    32'd0);

    // ---- Free run, divisor 0: H=2, period 4 ----
    bus.run_mode = 1'b1;
    reset        = 1'b1;
    step(1);
    chk("run_entry_state", {30'd0, bus.state},    32'd1);
    chk("run_entry_clk",   {31'd0, bus.clockCPU}, 32'd0);
    step(1);
    chk("run_pre_rise_clk", {31'd0, bus.clockCPU}, 32'd0);
    step(1);
    chk("run_first_rise_clk",  {31'd0, bus.clockCPU}, 32'd1);
    chk("run_first_rise_tick", {31'd0, bus.cpu_tick}, 32'd1);
    ticks = 0;
    step(16);
    chk("run_ticks_16cyc", ticks, 32'd4);
    chk("run_clk_after_16", {31'd0, bus.clockCPU}, 32'd1);

    // ---- Divisor 0->3 one cycle into a high phase ----
    step(1);
    bus.divisor = 4'd3;
    step(1);
    chk("div_old_len_fall", {31'd0, bus.clockCPU}, 32'd0);
    step(7);
    chk("div_new_low_still", {31'd0, bus.clockCPU}, 32'd0);
    step(1);
    chk("div_new_low_rise", {31'd0, bus.clockCPU}, 32'd1);
    chk("div_new_low_tick", {31'd0, bus.cpu_tick}, 32'd1);
    step(7);
    chk("div_high_still", {31'd0, bus.clockCPU}, 32'd1);
    step(1);
    chk("div_high_fall", {31'd0, bus.clockCPU}, 32'd0);

    // ---- Manual stepping ----
    do_reset(1'b0);
    bus.step_key_n = 1'b0;
    step(2);
    bus.step_key_n = 1'b1;
    step(30);
    chk("bounce_ticks", ticks, 32'd0);
    chk("bounce_state", {30'd0, bus.state}, 32'd0);

    ticks = 0; highs = 0;
    bus.step_key_n = 1'b0;
    step(6);
    chk("press_state_step", {30'd0, bus.state}, 32'd2);
    step(4);
    bus.step_key_n = 1'b1;
    step(30);
    chk("press10_ticks", ticks, 32'd1);
    chk("press10_highs", highs, 32'd2);
    chk("press10_idle",  {30'd0, bus.state}, 32'd0);

    ticks = 0; highs = 0;
    bus.step_key_n = 1'b0;
    step(200);
    chk("hold200_ticks", ticks, 32'd1);
    chk("hold200_highs", highs, 32'd2);
    ticks = 0;
    bus.step_key_n = 1'b1;
    step(20);
    chk("release_ticks", ticks, 32'd0);

    ticks = 0;
    bus.step_key_n = 1'b0;
    step(10);
    bus.step_key_n = 1'b1;
    step(30);
    chk("second_press_ticks", ticks, 32'd1);

    // ---- Breakpoint at 0x0C, PC advancing 4 per tick from 0 ----
    do_reset(1'b1);
    bus.bp_enable = 1'b1;
    bus.bp_addr   = 32'h0000000C;
    pc_auto       = 1'b1;
    step(13);
    chk("bp_ticks_to_break", ticks, 32'd3);
    chk("bp_state",  {30'd0, bus.state},    32'd3);
    chk("bp_halted", {31'd0, bus.halted},   32'd1);
    chk("bp_clk",    {31'd0, bus.clockCPU}, 32'd0);
    ticks = 0;
    step(10);
    chk("bp_hold_ticks", ticks, 32'd0);
    chk("bp_hold_state", {30'd0, bus.state}, 32'd3);

    bus.step_key_n = 1'b0;
    step(6);
    chk("bp_step_state",  {30'd0, bus.state},  32'd2);
    chk("bp_step_halted", {31'd0, bus.halted}, 32'd0);
    step(4);
    bus.step_key_n = 1'b1;
    chk("bp_step_ticks", ticks, 32'd1);
    chk("bp_resume_state", {30'd0, bus.state}, 32'd1);
    ticks = 0;
    step(20);
    chk("bp_resume_ticks",  ticks, 32'd5);
    chk("bp_resume_halted", {31'd0, bus.halted}, 32'd0);
    chk("bp_no_rebreak",    {30'd0, bus.state},  32'd1);

    // ---- run_mode dropped one cycle into a high phase ----
    do_reset(1'b1);
    step(3);
    chk("drop_rise", {31'd0, bus.clockCPU}, 32'd1);
    bus.run_mode = 1'b0;
    step(1);
    chk("drop_high_held", {31'd0, bus.clockCPU}, 32'd1);
    chk("drop_still_run", {30'd0, bus.state},    32'd1);
    step(1);
    chk("drop_fall_clk",   {31'd0, bus.clockCPU}, 32'd0);
    chk("drop_fall_state", {30'd0, bus.state},    32'd0);
    ticks = 0;
    step(20);
    chk("drop_no_ticks", ticks, 32'd0);

    // ---- Async reset while clockCPU is high during a step ----
    do_reset(1'b0);
    bus.step_key_n = 1'b0;
    step(8);
    chk("mid_step_high", {31'd0, bus.clockCPU}, 32'd1);
    #2;
    reset          = 1'b0;
    bus.step_key_n = 1'b1;
    #1;
    chk("async_rst_clk",    {31'd0, bus.clockCPU}, 32'd0);
    chk("async_rst_state",  {30'd0, bus.state},    32'd0);
    chk("async_rst_halted", {31'd0, bus.halted},   32'd0);
    step(2);
    reset = 1'b1;
    ticks = 0;
    step(30);
    chk("post_rst_no_tick", ticks, 32'd0);
    chk("post_rst_idle", {30'd0, bus.state}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
`default_nettype wire
